stroke_sequencer: RTL and testbench
===================================

Name: stroke_sequencer

Overview:
- Parametrised successor to the single-byte row sequencer.
- Buffers incoming words from the serial receiver in an internal FIFO and assembles multi-word command frames.
- Drives each frame to the pen/motor engine with a go/fin handshake, paced by an internal tick divider.
- Adds frame assembly, fin timeout, step/auto-continue mode, abort/flush, overflow flag and fill-level reporting.

Parameters:
- DATA_W, 8: width of one FIFO word.
- DEPTH, 16: FIFO depth in words; power of 2, at least 2, at least FRAME_LEN.
- FRAME_LEN, 2: words per command frame, 1..4.
- TICK_DIV, 200: clk cycles per sequencer tick, at least 2.
- TIMEOUT_TICKS, 65535: ticks allowed in WAIT_FIN before abandoning a frame; 0 disables the timeout.
- STEP_MODE, 1: 1 = wait for goon after each frame; 0 = auto-continue.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- in_data, input, DATA_W: word from the serial receiver.
- in_valid, input, 1: one-clk strobe; in_data is valid this cycle.
- in_full, output, 1: FIFO full, registered.
- level, output, clog2(DEPTH)+1: FIFO occupancy.
- overflow, output, 1: sticky; a write was dropped.
- cmd, output, DATA_W*FRAME_LEN: current frame; first-received word in the LSBs.
- go, output, 1: frame valid, engine may execute.
- fin, input, 1: asynchronous; a rising edge means the frame is done.
- goon, input, 1: asynchronous level; permission to continue (STEP_MODE=1 only).
- abort, input, 1: synchronous; flush the FIFO and return to IDLE.
- busy, output, 1: high when state is not IDLE.
- timeout, output, 1: one-clk pulse when a frame is abandoned.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: go=0, cmd=0, busy=0, timeout=0, overflow=0, in_full=0, level=0; FIFO pointers 0, tick counter 0, state IDLE, fin latch 0.
- Tick: a counter 0..TICK_DIV-1 wraps to 0; tick is high for one clk when the count equals TICK_DIV-1. Only state transitions marked "on tick" wait for it.
- Synchronisers: fin and goon each pass through two flops on clk. A rising edge of synchronised fin sets fin_seen; fin_seen holds until cleared, so pulses shorter than a tick are not lost.
- FIFO write: when in_valid=1 and in_full=0, write in_data and increment the write pointer; pointers wrap modulo DEPTH.
- FIFO overflow: when in_valid=1 and in_full=1, drop the word and set overflow, which stays set until rst.
- Simultaneous push and pop: both happen in the same cycle and level is unchanged; in_full is evaluated on its registered value.
- State machine:
  - IDLE: on tick, if level >= FRAME_LEN, go to LOAD with k=0. Otherwise stay in IDLE; a partial frame waits there indefinitely.
  - LOAD: every clk, pop one word into cmd slice k and increment k. After FRAME_LEN pops, go to ISSUE. Pops never underflow, because entry was guarded by the level check.
  - ISSUE: on tick, set go=1, clear fin_seen, clear the timeout counter, go to WAIT_FIN.
  - WAIT_FIN:
    - If fin_seen=1, set go=0; go to WAIT_GOON when STEP_MODE=1, otherwise to IDLE.
    - Else on tick, increment the timeout counter. If TIMEOUT_TICKS≠0 and the counter reaches TIMEOUT_TICKS, set go=0, pulse timeout for one clk, go to IDLE.
  - WAIT_GOON: on tick, if synchronised goon=1, go to IDLE.
- Hold rules: cmd holds its value from the end of LOAD until the next LOAD. go is high only in WAIT_FIN.
- Abort: abort=1 takes priority over everything except rst. In the same clk it sets go=0, state IDLE, empties the FIFO (pointers equal, level=0), and clears fin_seen and k. A write in the same cycle is dropped without setting overflow. The overflow flag and cmd are unchanged.
- Reset mid-operation: rst in any state yields all reset values on the next edge.
- fin timing: a fin rising edge seen outside WAIT_FIN is cleared at ISSUE and never acknowledges the next frame.
- Latency: from the tick that leaves IDLE to go=1 takes FRAME_LEN clk of LOAD plus the wait for the next tick.

Test Plan:
- TICK_DIV=4, FRAME_LEN=2, STEP_MODE=0. Write 0x11, 0x22; fin pulses 3 clk after go rises -> cmd=0x2211, go rises within 4+2+4 clk, go falls 3 clk after fin (2 sync + 1), busy returns to 0, level=0.
- Write 0xA1, 0xA2, 0xA3 with FRAME_LEN=2 -> one frame cmd=0xA2A1 is issued; after fin the sequencer stays IDLE with level=1. Writing 0xA4 then issues cmd=0xA4A3.
- DEPTH=4: write 6 words with no fin -> in_full=1 after 4 writes and overflow=1. One frame is popped into LOAD, leaving level=2 and in_full=0. overflow stays 1 until rst.
- STEP_MODE=1, TIMEOUT_TICKS=3: first frame gets fin -> sequencer waits in WAIT_GOON until goon=1. Second frame gets no fin -> timeout pulses exactly once after 3 ticks and go=0.
- abort asserted during WAIT_FIN with level=3 and in_valid=1 in the same cycle -> next clk go=0, busy=0, level=0, overflow unchanged, and a later fin pulse has no effect.
- rst asserted during LOAD -> all outputs at reset values next clk; subsequent writes of two words produce a correct frame.

Source files
------------

// File: rtl/stroke_sequencer.sv
// Stroke sequencer: buffers received words in a FIFO, assembles FRAME_LEN-word
// command frames and hands each one to the pen/motor engine with a go/fin handshake.
module stroke_sequencer #(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 16,
    parameter int FRAME_LEN     = 2,
    parameter int TICK_DIV      = 200,
    parameter int TIMEOUT_TICKS = 65535,
    parameter int STEP_MODE     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_full,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic [DATA_W*FRAME_LEN-1:0]   cmd,
    output logic                          go,
    input  logic                          fin,
    input  logic                          goon,
    input  logic                          abort,
    output logic                          busy,
    output logic                          timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_FIN  = 3'd3,
        WAIT_GOON = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [2:0]          k;
    logic [31:0]         to_cnt;
    logic                fin_p0, fin_p1, fin_p2;
    logic                goon_p0, goon_p1;
    logic                fin_rise;
    logic                fin_seen;
    logic                push;
    logic                pop;
    logic [LW-1:0]       level_nxt;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign fin_rise  = fin_p1 & ~fin_p2;
    assign push      = in_valid & ~in_full & ~abort;
    assign pop       = (state == LOAD) & ~abort;
    assign level_nxt = level + LW'(push) - LW'(pop);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // fin/goon are asynchronous: two flops each, plus one more on fin for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_p0  <= 1'b0;
            fin_p1  <= 1'b0;
            fin_p2  <= 1'b0;
            goon_p0 <= 1'b0;
            goon_p1 <= 1'b0;
        end else begin
            fin_p0  <= fin;
            fin_p1  <= fin_p0;
            fin_p2  <= fin_p1;
            goon_p0 <= goon;
            goon_p1 <= goon_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            in_full  <= 1'b0;
            overflow <= 1'b0;
            cmd      <= '0;
            go       <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            fin_seen <= 1'b0;
            k        <= '0;
            to_cnt   <= '0;
        end else begin
            timeout <= 1'b0;
            if (abort) begin
                // Flush: overflow and cmd deliberately survive an abort
                state    <= IDLE;
                go       <= 1'b0;
                busy     <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                in_full  <= 1'b0;
                fin_seen <= 1'b0;
                k        <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                level   <= level_nxt;
                in_full <= (level_nxt == LW'(DEPTH));
                if (in_valid && in_full) overflow <= 1'b1;
                if (fin_rise) fin_seen <= 1'b1;

                case (state)
                    IDLE: begin
                        if (tick && level >= LW'(FRAME_LEN)) begin
                            state <= LOAD;
                            k     <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        cmd[k*DATA_W +: DATA_W] <= mem[rd_ptr];
                        k <= k + 3'd1;
                        if (k == 3'(FRAME_LEN - 1)) state <= ISSUE;
                    end
                    ISSUE: begin
                        if (tick) begin
                            go       <= 1'b1;
                            fin_seen <= 1'b0;
                            to_cnt   <= '0;
                            state    <= WAIT_FIN;
                        end
                    end
                    WAIT_FIN: begin
                        // Acting on the raw edge as well saves a cycle of fin-to-release latency
                        if (fin_seen || fin_rise) begin
                            go <= 1'b0;
                            if (STEP_MODE != 0) begin
                                state <= WAIT_GOON;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (tick) begin
                            to_cnt <= to_cnt + 32'd1;
                            if (TIMEOUT_TICKS != 0 && (to_cnt + 32'd1) == 32'(TIMEOUT_TICKS)) begin
                                go      <= 1'b0;
                                timeout <= 1'b1;
                                state   <= IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    WAIT_GOON: begin
                        if (tick && goon_p1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stroke_sequencer.sv
// Directed bench for stroke_sequencer: three instances cover auto-continue,
// a shallow FIFO, and step mode with a short fin timeout.
module tb_stroke_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: auto-continue, DEPTH 16
    logic        a_rst, a_in_valid, a_fin, a_goon, a_abort;
    logic [7:0]  a_in_data;
    logic        a_in_full, a_overflow, a_go, a_busy, a_timeout;
    logic [4:0]  a_level;
    logic [15:0] a_cmd;
    // Instance B: DEPTH 4, slow tick so writes land between ticks
    logic        b_rst, b_in_valid, b_fin, b_goon, b_abort;
    logic [7:0]  b_in_data;
    logic        b_in_full, b_overflow, b_go, b_busy, b_timeout;
    logic [2:0]  b_level;
    logic [15:0] b_cmd;
    // Instance C: step mode, 3-tick timeout
    logic        c_rst, c_in_valid, c_fin, c_goon, c_abort;
    logic [7:0]  c_in_data;
    logic        c_in_full, c_overflow, c_go, c_busy, c_timeout;
    logic [4:0]  c_level;
    logic [15:0] c_cmd;

    stroke_sequencer #(.DATA_W(8), .DEPTH(16), .FRAME_LEN(2), .TICK_DIV(4),
                       .TIMEOUT_TICKS(65535), .STEP_MODE(0)) u_a (
        .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_full(a_in_full), .level(a_level), .overflow(a_overflow), .cmd(a_cmd),
        .go(a_go), .fin(a_fin), .goon(a_goon), .abort(a_abort), .busy(a_busy),
        .timeout(a_timeout));

    stroke_sequencer #(.DATA_W(8), .DEPTH(4), .FRAME_LEN(2), .TICK_DIV(32),
                       .TIMEOUT_TICKS(65535), .STEP_MODE(0)) u_b (
        .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_full(b_in_full), .level(b_level), .overflow(b_overflow), .cmd(b_cmd),
        .go(b_go), .fin(b_fin), .goon(b_goon), .abort(b_abort), .busy(b_busy),
        .timeout(b_timeout));

    stroke_sequencer #(.DATA_W(8), .DEPTH(16), .FRAME_LEN(2), .TICK_DIV(4),
                       .TIMEOUT_TICKS(3), .STEP_MODE(1)) u_c (
        .clk(clk), .rst(c_rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_full(c_in_full), .level(c_level), .overflow(c_overflow), .cmd(c_cmd),
        .go(c_go), .fin(c_fin), .goon(c_goon), .abort(c_abort), .busy(c_busy),
        .timeout(c_timeout));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic go_of(input int w);
        case (w)
            0:       return a_go;
            1:       return b_go;
            default: return c_go;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    task automatic write_word(input int w, input logic [7:0] d);
        case (w)
            0:       begin a_in_data = d; a_in_valid = 1'b1; end
            1:       begin b_in_data = d; b_in_valid = 1'b1; end
            default: begin c_in_data = d; c_in_valid = 1'b1; end
        endcase
        step(1);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    task automatic pulse_fin(input int w);
        case (w)
            0:       a_fin = 1'b1;
            1:       b_fin = 1'b1;
            default: c_fin = 1'b1;
        endcase
        step(1);
        a_fin = 1'b0;
        b_fin = 1'b0;
        c_fin = 1'b0;
    endtask

    task automatic wait_go(input int w, input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (go_of(w)) break;
            step(1);
        end
        check(tag, go_of(w), 1'b1);
    endtask

    task automatic wait_busy(input int w, input logic val, input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (busy_of(w) == val) break;
            step(1);
        end
        check(tag, busy_of(w), val);
    endtask

    // fin pulse, then go must still be high 2 clk after the drive and low at 3 clk
    task automatic finish_frame(input int w, input string tag);
        pulse_fin(w);
        step(1);
        check({tag, "_go_hold"}, go_of(w), 1'b1);
        step(1);
        check({tag, "_go_fall"}, go_of(w), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmo_count;
        int tmo_at;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_fin = 1'b0; b_fin = 1'b0; c_fin = 1'b0;
        a_goon = 1'b0; b_goon = 1'b0; c_goon = 1'b0;
        a_abort = 1'b0; b_abort = 1'b0; c_abort = 1'b0;
        step(3);

        check("rst_go",       a_go, 1'b0);
        check("rst_cmd",      a_cmd, 16'h0000);
        check("rst_busy",     a_busy, 1'b0);
        check("rst_timeout",  a_timeout, 1'b0);
        check("rst_overflow", a_overflow, 1'b0);
        check("rst_in_full",  a_in_full, 1'b0);
        check("rst_level",    a_level, 5'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        step(1);

        // Basic frame, auto-continue
        write_word(0, 8'h11);
        write_word(0, 8'h22);
        wait_go(0, "t1_go_rise", 10);
        check("t1_cmd", a_cmd, 16'h2211);
        check("t1_busy", a_busy, 1'b1);
        check("t1_level", a_level, 5'd0);
        step(2);
        finish_frame(0, "t1");
        check("t1_busy_idle", a_busy, 1'b0);
        check("t1_level_end", a_level, 5'd0);

        // Three words: one frame, one word left waiting
        write_word(0, 8'hA1);
        write_word(0, 8'hA2);
        write_word(0, 8'hA3);
        wait_go(0, "t2_go_rise", 12);
        check("t2_cmd", a_cmd, 16'hA2A1);
        check("t2_level", a_level, 5'd1);
        finish_frame(0, "t2");
        step(12);
        check("t2_partial_idle", a_busy, 1'b0);
        check("t2_partial_level", a_level, 5'd1);
        write_word(0, 8'hA4);
        wait_go(0, "t2b_go_rise", 12);
        check("t2b_cmd", a_cmd, 16'hA4A3);
        finish_frame(0, "t2b");

        // Abort in WAIT_FIN with a write in the same cycle
        write_word(0, 8'hB1);
        write_word(0, 8'hB2);
        wait_go(0, "ab_go_rise", 12);
        write_word(0, 8'hC1);
        write_word(0, 8'hC2);
        write_word(0, 8'hC3);
        check("ab_level_pre", a_level, 5'd3);
        a_abort = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hEE;
        step(1);
        a_abort = 1'b0; a_in_valid = 1'b0;
        check("ab_go", a_go, 1'b0);
        check("ab_busy", a_busy, 1'b0);
        check("ab_level", a_level, 5'd0);
        check("ab_in_full", a_in_full, 1'b0);
        check("ab_overflow", a_overflow, 1'b0);
        check("ab_cmd_kept", a_cmd, 16'hB2B1);
        pulse_fin(0);
        step(6);
        check("ab_fin_ignored_busy", a_busy, 1'b0);
        check("ab_fin_ignored_level", a_level, 5'd0);
        write_word(0, 8'hD1);
        write_word(0, 8'hD2);
        wait_go(0, "ab_next_go", 12);
        check("ab_next_cmd", a_cmd, 16'hD2D1);
        step(5);
        check("ab_stale_fin", a_go, 1'b1);
        finish_frame(0, "ab_next");

        // Reset during LOAD
        write_word(0, 8'hE1);
        write_word(0, 8'hE2);
        wait_busy(0, 1'b1, "rl_load_entry", 8);
        a_rst = 1'b1;
        step(1);
        a_rst = 1'b0;
        check("rl_go", a_go, 1'b0);
        check("rl_cmd", a_cmd, 16'h0000);
        check("rl_busy", a_busy, 1'b0);
        check("rl_level", a_level, 5'd0);
        check("rl_in_full", a_in_full, 1'b0);
        check("rl_overflow", a_overflow, 1'b0);
        check("rl_timeout", a_timeout, 1'b0);
        write_word(0, 8'hF1);
        write_word(0, 8'hF2);
        wait_go(0, "rl_go_rise", 12);
        check("rl_cmd_after", a_cmd, 16'hF2F1);
        finish_frame(0, "rl");

        // Shallow FIFO: full and overflow
        b_rst = 1'b1;
        step(1);
        b_rst = 1'b0;
        write_word(1, 8'h01);
        write_word(1, 8'h02);
        write_word(1, 8'h03);
        check("ov_not_full3", b_in_full, 1'b0);
        write_word(1, 8'h04);
        check("ov_full4", b_in_full, 1'b1);
        check("ov_level4", b_level, 3'd4);
        check("ov_clear4", b_overflow, 1'b0);
        write_word(1, 8'h05);
        write_word(1, 8'h06);
        check("ov_set", b_overflow, 1'b1);
        check("ov_level_held", b_level, 3'd4);
        wait_go(1, "ov_go_rise", 80);
        check("ov_cmd", b_cmd, 16'h0201);
        check("ov_level2", b_level, 3'd2);
        check("ov_full_cleared", b_in_full, 1'b0);
        step(10);
        check("ov_sticky", b_overflow, 1'b1);
        b_rst = 1'b1;
        step(1);
        b_rst = 1'b0;
        check("ov_rst_clear", b_overflow, 1'b0);
        check("ov_rst_level", b_level, 3'd0);

        // Step mode: WAIT_GOON, then timeout on an unanswered frame
        write_word(2, 8'h31);
        write_word(2, 8'h32);
        wait_go(2, "st_go_rise", 12);
        check("st_cmd", c_cmd, 16'h3231);
        finish_frame(2, "st");
        step(10);
        check("st_wait_goon", c_busy, 1'b1);
        c_goon = 1'b1;
        wait_busy(2, 1'b0, "st_goon_release", 10);
        c_goon = 1'b0;
        write_word(2, 8'h41);
        write_word(2, 8'h42);
        wait_go(2, "to_go_rise", 12);
        check("to_cmd", c_cmd, 16'h4241);
        tmo_count = 0;
        tmo_at = 0;
        for (int j = 1; j <= 30; j++) begin
            step(1);
            if (c_timeout) begin
                tmo_count++;
                if (tmo_at == 0) begin
                    tmo_at = j;
                    check("to_go_low", c_go, 1'b0);
                end
            end
        end
        check("to_pulse_count", tmo_count, 1);
        check("to_latency", tmo_at, 12);
        check("to_busy_idle", c_busy, 1'b0);
        check("to_go_end", c_go, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
